wbu_master_ctrl: RTL and testbench

//  Parametrised Wishbone B4 classic master between the pipeline memory stage and the bus.

---
 rtl/wbu_master_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_wbu_master_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbu_master_ctrl.sv
// wbu_master_ctrl: Wishbone B4 classic master between the memory stage and the bus.
// This block latches one load or store request and runs a single classic bus cycle for it.
// It places store data on the byte lanes and drives the byte selects. For loads it takes the
// selected lanes from the read data and zero- or sign-extends them. Misaligned requests
// finish with an error and no bus cycle. A kill, a slave error or the watchdog ends the access.
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   wbm_we_i / wbm_re_i          store / load request (both or neither = no request)
//   wbm_kill_i                   abort the current or pending access
//   wbm_addr_i, wbm_dat_i        byte address, right-justified store data
//   wbm_size_i, wbm_signed_i     00 byte, 01 half, 10 word, 11 dword; sign-extend loads
//   wbm_dat_o                    extended load data, held until the next good load
//   wbm_stall_o                  pipeline must hold
//   wbm_done_o, wbm_err_o        completion pulse, error flag (valid with done)
//   wbm_cyc_o                    copy of wbs_cyc_o
//   wbs_*                        Wishbone classic master side (outputs registered)
module wbu_master_ctrl #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wbm_we_i,
    input  logic            wbm_re_i,
    input  logic            wbm_kill_i,
    input  logic [AW-1:0]   wbm_addr_i,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic [1:0]      wbm_size_i,
    input  logic            wbm_signed_i,
    output logic [DW-1:0]   wbm_dat_o,
    output logic            wbm_stall_o,
    output logic            wbm_done_o,
    output logic            wbm_err_o,
    output logic            wbm_cyc_o,
    output logic [AW-1:0]   wbs_adr_o,
    output logic [DW-1:0]   wbs_dat_o,
    input  logic [DW-1:0]   wbs_dat_i,
    output logic [DW/8-1:0] wbs_sel_o,
    output logic            wbs_cyc_o,
    output logic            wbs_stb_o,
    output logic            wbs_we_o,
    input  logic            wbs_ack_i,
    input  logic            wbs_err_i
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned OW = $clog2(SW);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_TRAN = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    logic [2:0]    state_q;
    logic [TW-1:0] timer_q;
    logic [OW-1:0] off_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic          err_q;

    logic          req;
    logic [OW-1:0] off_in;
    logic [OW-1:0] align_mask;
    logic [SW-1:0] lane_base;
    logic          misalign;
    logic [DW-1:0] rep_dat;
    logic [DW-1:0] shifted;
    logic [DW-1:0] ld_dat;
    logic          ld_msb;
    int            ld_bits;

    assign req         = wbm_we_i ^ wbm_re_i;
    assign off_in      = wbm_addr_i[OW-1:0];
    assign wbm_cyc_o   = wbs_cyc_o;
    assign wbm_done_o  = state_q[2];
    assign wbm_err_o   = state_q[2] & err_q;
    // Gated by reset so the pipeline sees no stall while reset is asserted.
    assign wbm_stall_o = ~rst_i & (state_q[1] | (state_q[0] & req & ~wbm_kill_i));

    // Request decode: alignment mask and unshifted lane mask for the requested size.
    always_comb begin
        case (wbm_size_i)
            2'b00:   begin align_mask = '0;        lane_base = SW'(1);   end
            2'b01:   begin align_mask = OW'(1);    lane_base = SW'(3);   end
            2'b10:   begin align_mask = OW'(3);    lane_base = SW'(15);  end
            default: begin align_mask = OW'(7);    lane_base = SW'(255); end
        endcase
        misalign = ((off_in & align_mask) != '0) || ((wbm_size_i == 2'b11) && (DW == 32));
    end

    // Store data is repeated into every size-aligned slot so any lane offset sees it.
    always_comb begin
        rep_dat = '0;
        for (int i = 0; i < SW; i++) begin
            case (wbm_size_i)
                2'b00:   rep_dat[8*i +: 8] = wbm_dat_i[7:0];
                2'b01:   rep_dat[8*i +: 8] = wbm_dat_i[8*(i%2) +: 8];
                2'b10:   rep_dat[8*i +: 8] = wbm_dat_i[8*(i%4) +: 8];
                default: rep_dat[8*i +: 8] = wbm_dat_i[8*(i%8) +: 8];
            endcase
        end
    end

    // Load path: right-justify the addressed lanes, then extend above the access width.
    always_comb begin
        shifted = wbs_dat_i >> {off_q, 3'b000};
        case (size_q)
            2'b00:   begin ld_bits = 8;  ld_msb = shifted[7];    end
            2'b01:   begin ld_bits = 16; ld_msb = shifted[15];   end
            2'b10:   begin ld_bits = 32; ld_msb = shifted[31];   end
            default: begin ld_bits = DW; ld_msb = shifted[DW-1]; end
        endcase
        ld_dat = shifted;
        for (int b = 0; b < DW; b++) begin
            if (b >= ld_bits) ld_dat[b] = sgn_q & ld_msb;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            err_q     <= 1'b0;
            wbm_dat_o <= '0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_sel_o <= '0;
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            wbs_we_o  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req && !wbm_kill_i) begin
                        off_q  <= off_in;
                        size_q <= wbm_size_i;
                        sgn_q  <= wbm_signed_i;
                        if (misalign) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_q     <= 1'b0;
                            wbs_cyc_o <= 1'b1;
                            wbs_stb_o <= 1'b1;
                            wbs_we_o  <= wbm_we_i;
                            wbs_adr_o <= {wbm_addr_i[AW-1:OW], {OW{1'b0}}};
                            wbs_dat_o <= rep_dat;
                            wbs_sel_o <= lane_base << off_in;
                            timer_q   <= '0;
                            state_q   <= S_TRAN;
                        end
                    end
                end
                S_TRAN: begin
                    if (wbm_kill_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (wbs_err_i) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (wbs_ack_i) begin
                        if (!wbs_we_o) wbm_dat_o <= ld_dat;
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        err_q     <= 1'b0;
                        state_q   <= S_DONE;
                    end else if ((TIMEOUT != 0) && (timer_q == TW'(TIMEOUT))) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (timer_q != {TW{1'b1}}) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wbu_master_ctrl.sv
// Testbench for wbu_master_ctrl (DW=32, TIMEOUT=4) with a simple Wishbone slave model.
// Each access pushes its expected load data and error flag to a scoreboard queue. A monitor
// pops and compares them on every done pulse.
module tb_wbu_master_ctrl;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            wbm_we_i, wbm_re_i, wbm_kill_i, wbm_signed_i;
    logic [AW-1:0]   wbm_addr_i;
    logic [DW-1:0]   wbm_dat_i;
    logic [1:0]      wbm_size_i;
    logic [DW-1:0]   wbm_dat_o;
    logic            wbm_stall_o, wbm_done_o, wbm_err_o, wbm_cyc_o;
    logic [AW-1:0]   wbs_adr_o;
    logic [DW-1:0]   wbs_dat_o, wbs_dat_i;
    logic [DW/8-1:0] wbs_sel_o;
    logic            wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i, wbs_err_i;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } exp_t;
    exp_t          sb_q[$];
    logic [DW-1:0] model_dat = '0;

    // Slave model: responds once stb has been high for slv_delay edges.
    logic          slv_silent = 1'b0;
    logic          slv_ack_en = 1'b1;
    logic          slv_err_en = 1'b0;
    int            slv_delay  = 0;
    logic [DW-1:0] slv_rdata  = '0;
    int            stb_cnt;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stb_cnt <= 0;
        else       stb_cnt <= (wbs_cyc_o && wbs_stb_o) ? stb_cnt + 1 : 0;
    end

    assign wbs_ack_i = wbs_cyc_o & wbs_stb_o & ~slv_silent & (stb_cnt >= slv_delay) & slv_ack_en;
    assign wbs_err_i = wbs_cyc_o & wbs_stb_o & ~slv_silent & (stb_cnt >= slv_delay) & slv_err_en;
    assign wbs_dat_i = slv_rdata;

    always #5 clk_i = ~clk_i;

    wbu_master_ctrl #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wbm_we_i     (wbm_we_i),
        .wbm_re_i     (wbm_re_i),
        .wbm_kill_i   (wbm_kill_i),
        .wbm_addr_i   (wbm_addr_i),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_size_i   (wbm_size_i),
        .wbm_signed_i (wbm_signed_i),
        .wbm_dat_o    (wbm_dat_o),
        .wbm_stall_o  (wbm_stall_o),
        .wbm_done_o   (wbm_done_o),
        .wbm_err_o    (wbm_err_o),
        .wbm_cyc_o    (wbm_cyc_o),
        .wbs_adr_o    (wbs_adr_o),
        .wbs_dat_o    (wbs_dat_o),
        .wbs_dat_i    (wbs_dat_i),
        .wbs_sel_o    (wbs_sel_o),
        .wbs_cyc_o    (wbs_cyc_o),
        .wbs_stb_o    (wbs_stb_o),
        .wbs_we_o     (wbs_we_o),
        .wbs_ack_i    (wbs_ack_i),
        .wbs_err_i    (wbs_err_i)
    );

    // Scoreboard monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk_i) begin
        if (!rst_i && wbm_done_o) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: got done with dat=%h err=%b, none expected",
                         wbm_dat_o, wbm_err_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (wbm_dat_o !== e.dat || wbm_err_o !== e.err) begin
                    miscompares++;
                    $display("FAIL sb_done: got dat=%h err=%b, expected dat=%h err=%b",
                             wbm_dat_o, wbm_err_o, e.dat, e.err);
                end
            end
        end
    end

    // Drive one access, hold the request until done, then let DONE retire to IDLE.
    task automatic do_access(input logic we, input logic re, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdat, input logic [1:0] size,
                             input logic sgn, input logic [DW-1:0] exp_dat,
                             input logic exp_err, output int lat, output int cyc_cnt,
                             output logic [AW-1:0] s_adr, output logic [3:0] s_sel,
                             output logic s_we, output logic [DW-1:0] s_dat,
                             output logic cyc_at_done);
        exp_t e;
        if (re && !exp_err) model_dat = exp_dat;
        e.dat = model_dat;
        e.err = exp_err;
        sb_q.push_back(e);
        lat = 0; cyc_cnt = 0; s_adr = '0; s_sel = '0; s_we = 1'b0; s_dat = '0;
        wbm_we_i = we; wbm_re_i = re; wbm_addr_i = addr; wbm_dat_i = wdat;
        wbm_size_i = size; wbm_signed_i = sgn;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            lat++;
            if (wbs_cyc_o) cyc_cnt++;
            if (lat == 1) begin
                s_adr = wbs_adr_o; s_sel = wbs_sel_o; s_we = wbs_we_o; s_dat = wbs_dat_o;
            end
            if (wbm_done_o) break;
        end
        cyc_at_done = wbs_cyc_o;
        if (!wbm_done_o) begin
            vectors++;
            miscompares++;
            $display("FAIL access_timeout: no done within %0d cycles for addr %h", lat, addr);
        end
        wbm_we_i = 1'b0; wbm_re_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    int            lat, cyc_cnt;
    logic [AW-1:0] s_adr;
    logic [3:0]    s_sel;
    logic          s_we, cyc_at_done;
    logic [DW-1:0] s_dat;

    task automatic test_reset();
        rst_i = 1'b1;
        wbm_we_i = 1'b0; wbm_re_i = 1'b0; wbm_kill_i = 1'b0; wbm_signed_i = 1'b0;
        wbm_addr_i = '0; wbm_dat_i = '0; wbm_size_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        vectors++;
        if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_stall_o, wbm_done_o, wbm_err_o, wbm_cyc_o}
            !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got cyc/stb/we/stall/done/err/mcyc=%b, expected 0000000",
                     {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_stall_o, wbm_done_o, wbm_err_o,
                      wbm_cyc_o});
        end
        vectors++;
        if (wbm_dat_o !== '0 || wbs_adr_o !== '0 || wbs_sel_o !== '0 || wbs_dat_o !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got dat_o=%h adr=%h sel=%b wdat=%h, expected all 0",
                     wbm_dat_o, wbs_adr_o, wbs_sel_o, wbs_dat_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_word_load();
        slv_silent = 1'b0; slv_ack_en = 1'b1; slv_err_en = 1'b0; slv_delay = 0;
        slv_rdata = 32'hDEADBEEF;
        do_access(1'b0, 1'b1, 32'h100, '0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (s_sel !== 4'b1111 || s_adr !== 32'h100 || s_we !== 1'b0) begin
            miscompares++;
            $display("FAIL word_load_bus: got sel=%b adr=%h we=%b, expected 1111 00000100 0",
                     s_sel, s_adr, s_we);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL word_load_latency: got %0d cycles, expected 2", lat);
        end
    endtask

    task automatic test_byte_load();
        slv_rdata = 32'h80000000;
        do_access(1'b0, 1'b1, 32'h103, '0, 2'b00, 1'b1, 32'hFFFFFF80, 1'b0,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (s_sel !== 4'b1000 || s_adr !== 32'h100) begin
            miscompares++;
            $display("FAIL byte_load_bus: got sel=%b adr=%h, expected 1000 00000100",
                     s_sel, s_adr);
        end
        do_access(1'b0, 1'b1, 32'h103, '0, 2'b00, 1'b0, 32'h00000080, 1'b0,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
    endtask

    task automatic test_half_store();
        slv_rdata = 32'h11111111;
        do_access(1'b1, 1'b0, 32'h202, 32'h0000A5A5, 2'b01, 1'b0, '0, 1'b0,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (s_sel !== 4'b1100 || s_adr !== 32'h200 || s_we !== 1'b1 ||
            s_dat !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL half_store_bus: got sel=%b adr=%h we=%b wdat=%h, expected 1100 00000200 1 a5a5a5a5",
                     s_sel, s_adr, s_we, s_dat);
        end
    endtask

    task automatic test_misaligned();
        do_access(1'b0, 1'b1, 32'h101, '0, 2'b10, 1'b0, '0, 1'b1,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (lat !== 1 || cyc_cnt !== 0) begin
            miscompares++;
            $display("FAIL misalign_word: got lat=%0d cyc_cycles=%0d, expected 1 0", lat, cyc_cnt);
        end
        do_access(1'b0, 1'b1, 32'h3, '0, 2'b01, 1'b0, '0, 1'b1,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (lat !== 1 || cyc_cnt !== 0) begin
            miscompares++;
            $display("FAIL misalign_half: got lat=%0d cyc_cycles=%0d, expected 1 0", lat, cyc_cnt);
        end
        do_access(1'b0, 1'b1, 32'h0, '0, 2'b11, 1'b0, '0, 1'b1,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (lat !== 1 || cyc_cnt !== 0) begin
            miscompares++;
            $display("FAIL dword_on_dw32: got lat=%0d cyc_cycles=%0d, expected 1 0", lat, cyc_cnt);
        end
    endtask

    task automatic test_timeout();
        slv_silent = 1'b1;
        do_access(1'b0, 1'b1, 32'h40, '0, 2'b10, 1'b0, '0, 1'b1,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (cyc_cnt !== 5 || lat !== 6 || cyc_at_done !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: got cyc_cycles=%0d lat=%0d cyc_at_done=%b, expected 5 6 0",
                     cyc_cnt, lat, cyc_at_done);
        end
        slv_silent = 1'b0;
    endtask

    task automatic test_err_ack();
        slv_ack_en = 1'b1; slv_err_en = 1'b1; slv_rdata = 32'h55555555;
        do_access(1'b0, 1'b1, 32'h44, '0, 2'b10, 1'b0, '0, 1'b1,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL err_ack_latency: got %0d cycles, expected 2", lat);
        end
        slv_err_en = 1'b0;
    endtask

    task automatic test_kill();
        int dones;
        dones = 0;
        slv_silent = 1'b1;
        wbm_re_i = 1'b1; wbm_addr_i = 32'h80; wbm_size_i = 2'b10;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        vectors++;
        if (wbs_cyc_o !== 1'b1 || wbm_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_pre: got cyc=%b stall=%b, expected 1 1", wbs_cyc_o, wbm_stall_o);
        end
        wbm_kill_i = 1'b1;
        @(posedge clk_i); #1;
        vectors++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || wbm_stall_o !== 1'b0 ||
            wbm_done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL kill: got cyc=%b stb=%b stall=%b done=%b, expected 0 0 0 0",
                     wbs_cyc_o, wbs_stb_o, wbm_stall_o, wbm_done_o);
        end
        wbm_kill_i = 1'b0; wbm_re_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            if (wbm_done_o) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL kill_no_done: got %0d done pulses, expected 0", dones);
        end
        slv_silent = 1'b0;
    endtask

    task automatic test_reset_mid();
        slv_silent = 1'b1;
        wbm_re_i = 1'b1; wbm_addr_i = 32'h80; wbm_size_i = 2'b10;
        @(posedge clk_i); #1;
        vectors++;
        if (wbs_cyc_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got cyc=%b, expected 1", wbs_cyc_o);
        end
        rst_i = 1'b1;
        #1;
        vectors++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || wbm_stall_o !== 1'b0 ||
            wbm_dat_o !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got cyc=%b stb=%b stall=%b dat_o=%h, expected 0 0 0 0",
                     wbs_cyc_o, wbs_stb_o, wbm_stall_o, wbm_dat_o);
        end
        model_dat = '0;
        @(posedge clk_i); #1;
        wbm_re_i = 1'b0;
        rst_i = 1'b0;
        slv_silent = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_back_to_back();
        slv_delay = 1;
        slv_rdata = 32'h12345678;
        do_access(1'b0, 1'b1, 32'h106, '0, 2'b01, 1'b0, 32'h00001234, 1'b0,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (lat !== 3 || s_sel !== 4'b1100) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d sel=%b, expected 3 1100", lat, s_sel);
        end
        slv_rdata = 32'h12348001;
        do_access(1'b0, 1'b1, 32'h104, '0, 2'b01, 1'b1, 32'hFFFF8001, 1'b0,
                  lat, cyc_cnt, s_adr, s_sel, s_we, s_dat, cyc_at_done);
        vectors++;
        if (lat !== 3 || s_sel !== 4'b0011) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d sel=%b, expected 3 0011", lat, s_sel);
        end
        slv_delay = 0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_err_ack();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk_i);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
